alu_word_sequencer: RTL and testbench

Multi-cycle controller that drives the 8-bit ALU to run word-width operations, one byte per clock, LSB first. It chains carry/borrow between bytes and aggregates flags across the word. It sits between the datapath control unit, which issues a word operation with a start/done handshake, and the single shared 8-bit ALU instance, whose operand, opcode and carry-in ports it owns while busy.

---
 rtl/alu_word_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_word_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
// Word-width operation sequencer: drives a shared 8-bit ALU one byte per clock, LSB first,
// chaining carry/borrow between bytes and folding the per-byte flags into word flags.

package alu_word_sequencer_pkg;
  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;
  localparam logic [2:0] SUB_FN  = 3'd2;
  localparam logic [2:0] SUBC_FN = 3'd3;
  localparam logic [2:0] AND_FN  = 3'd4;
  localparam logic [2:0] OR_FN   = 3'd5;
endpackage

module alu_word_sequencer
  import alu_word_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic [8*NBYTES-1:0]   result,
  output logic                  c_flag,
  output logic                  z_flag,
  output logic                  n_flag,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            alu_in1,
  output logic [7:0]            alu_in2,
  output logic [2:0]            alu_opcode,
  output logic                  alu_cin,
  input  logic [7:0]            alu_out,
  input  logic                  alu_c,
  input  logic                  alu_z
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic            cin_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            zacc_q;
  logic            accept;
  logic            arith;
  logic            is_add;
  logic            last;
  logic [W-1:0]    a_sh, b_sh;

  assign arith  = (op_q == ADD_FN) || (op_q == ADDC_FN) || (op_q == SUB_FN) || (op_q == SUBC_FN);
  assign is_add = (op_q == ADD_FN) || (op_q == ADDC_FN);
  assign last   = (idx_q == IW'(NBYTES - 1));
  assign a_sh   = a_q >> {idx_q, 3'b000};
  assign b_sh   = b_q >> {idx_q, 3'b000};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    alu_in1    = 8'h00;
    alu_in2    = 8'h00;
    alu_opcode = op_q;
    alu_cin    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        alu_in1 = a_sh[7:0];
        alu_in2 = b_sh[7:0];
        if (idx_q == '0) begin
          alu_cin = cin_q;
        end else if (arith) begin
          // Upper bytes always chain through the carry-consuming variant.
          alu_opcode = is_add ? ADDC_FN : SUBC_FN;
          alu_cin    = carry_q;
        end
        if (last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ADD_FN;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      result  <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      cin_q   <= cin;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
    end else if (busy) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx_q == IW'(i)) result[8*i +: 8] <= alu_out;
      end
      // The ALU carry output is meaningless for logic functions.
      carry_q <= arith & alu_c;
      zacc_q  <= zacc_q & alu_z;
      if (last) begin
        c_flag <= arith & alu_c;
        z_flag <= zacc_q & alu_z;
        n_flag <= alu_out[7];
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer (NBYTES=4) with a behavioural 8-bit ALU attached;
// word results are scoreboarded at start and compared when done pulses.

module tb_alu_word_sequencer;
  import alu_word_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic        c_flag, z_flag, n_flag, busy, done;
  logic [7:0]  alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_opcode;
  logic        alu_cin, alu_c, alu_z;
  logic [8:0]  alu_sum;

  alu_word_sequencer #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .result(result), .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag),
    .busy(busy), .done(done), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // Shared ALU model; logic functions deliberately report a carry of 1.
  always_comb begin
    case (alu_opcode)
      ADD_FN:  alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
      ADDC_FN: alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'b0, alu_cin};
      SUB_FN:  alu_sum = {1'b0, alu_in1} - {1'b0, alu_in2};
      SUBC_FN: alu_sum = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'b0, alu_cin};
      AND_FN:  alu_sum = {1'b1, alu_in1 & alu_in2};
      OR_FN:   alu_sum = {1'b1, alu_in1 | alu_in2};
      default: alu_sum = 9'h1FF;
    endcase
  end
  assign alu_out = alu_sum[7:0];
  assign alu_c   = alu_sum[8];
  assign alu_z   = (alu_sum[7:0] == 8'h00);

  typedef struct packed {
    logic [2:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c, z, n;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        c, z, n;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("flags c/z/n", 64'({c_flag, z_flag, n_flag}), 64'({e.c, e.z, e.n}));
      end
    end
  end

  function automatic logic [11:0] exp_opcodes(input logic [2:0] f);
    logic [2:0] hi;
    if (f == ADD_FN || f == ADDC_FN)      hi = ADDC_FN;
    else if (f == SUB_FN || f == SUBC_FN) hi = SUBC_FN;
    else                                  hi = f;
    return {hi, hi, hi, f};
  endfunction

  task automatic run_op(input vec_t v, output logic [3:0] cins);
    logic [11:0] ops;
    logic [31:0] in1s, in2s;
    logic [5:1]  busy_tr, done_tr;
    @(negedge clk);
    op = v.op; cin = v.cin; a = v.a; b = v.b; start = 1'b1;
    sb.push_back('{res: v.res, c: v.c, z: v.z, n: v.n});
    ops = '0; in1s = '0; in2s = '0; cins = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      busy_tr[c] = busy;
      done_tr[c] = done;
      if (c <= 4) begin
        ops[3*(c-1) +: 3]  = alu_opcode;
        in1s[8*(c-1) +: 8] = alu_in1;
        in2s[8*(c-1) +: 8] = alu_in2;
        cins[c-1]          = alu_cin;
      end
    end
    check("busy cycles 1-4", 64'(busy_tr), 64'(5'b01111));
    check("done at cycle 5", 64'(done_tr), 64'(5'b10000));
    check("alu_opcode per byte", 64'(ops), 64'(exp_opcodes(v.op)));
    check("alu_in1 bytes", 64'(in1s), 64'(v.a));
    check("alu_in2 bytes", 64'(in2s), 64'(v.b));
  endtask

  vec_t        vecs[13];
  logic [3:0]  cins;
  logic [10:1] busy_tr, done_tr, exp_busy, exp_done;
  logic [5:1]  idle_tr;

  initial begin
    vecs = '{
      '{ADD_FN,  1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0},
      '{ADD_FN,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0},
      '{SUB_FN,  1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1},
      '{ADDC_FN, 1'b1, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b1},
      '{SUBC_FN, 1'b1, 32'h00000100, 32'h00000000, 32'h000000FF, 1'b0, 1'b0, 1'b0},
      '{AND_FN,  1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b1, 1'b0},
      '{OR_FN,   1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1},
      '{SUB_FN,  1'b0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0},
      '{ADDC_FN, 1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0},
      '{ADD_FN,  1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0},
      '{SUBC_FN, 1'b1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1},
      '{AND_FN,  1'b1, 32'hFFFF0000, 32'hFF00FF00, 32'hFF000000, 1'b0, 1'b0, 1'b1},
      '{ADD_FN,  1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0, 1'b0}
    };

    rst = 1'b1; start = 1'b0; op = ADD_FN; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset result", 64'(result), 64'(0));
    check("reset flags", 64'({c_flag, z_flag, n_flag}), 64'(0));
    check("reset busy/done", 64'({busy, done}), 64'(0));
    check("reset alu drive", 64'({alu_in1, alu_in2, alu_cin}), 64'(0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i], cins);
      if (i == 0) check("byte1 alu_cin after FF+01", 64'(cins[1]), 64'(1));
      if (vecs[i].op == AND_FN || vecs[i].op == OR_FN)
        check("logic alu_cin upper bytes", 64'(cins[3:1]), 64'(0));
    end

    // Start while busy is ignored; start held in DONE chains without an idle gap.
    @(negedge clk);
    op = ADD_FN; cin = 1'b0; a = 32'h11111111; b = 32'h22222222; start = 1'b1;
    sb.push_back('{res: 32'h33333333, c: 1'b0, z: 1'b0, n: 1'b0});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      busy_tr[c]  = busy;
      done_tr[c]  = done;
      exp_busy[c] = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      exp_done[c] = (c == 5) || (c == 10);
      start = (c == 2) || (c == 5);
      if (c == 2) begin
        op = ADD_FN; a = 32'hFFFFFFFF; b = 32'h00000001;
      end
      if (c == 5) begin
        op = SUB_FN; a = 32'h00000005; b = 32'h00000007;
        sb.push_back('{res: 32'hFFFFFFFE, c: 1'b1, z: 1'b0, n: 1'b1});
      end
    end
    start = 1'b0;
    check("busy trace back-to-back", 64'(busy_tr), 64'(exp_busy));
    check("done trace back-to-back", 64'(done_tr), 64'(exp_done));

    // Reset in the middle of an operation, with a simultaneous start.
    @(negedge clk);
    op = ADD_FN; cin = 1'b0; a = 32'h01020304; b = 32'h10203040; start = 1'b1;
    sb.push_back('{res: 32'h11223344, c: 1'b0, z: 1'b0, n: 1'b0});
    repeat (2) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort busy/done", 64'({busy, done}), 64'(0));
    check("abort result", 64'(result), 64'(0));
    check("abort flags", 64'({c_flag, z_flag, n_flag}), 64'(0));
    check("abort alu drive", 64'({alu_in1, alu_in2, alu_cin}), 64'(0));
    sb.delete();
    rst = 1'b0; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      idle_tr[c] = busy | done;
    end
    check("no activity after abort", 64'(idle_tr), 64'(0));
    run_op('{ADD_FN, 1'b0, 32'h89ABCDEF, 32'h76543211, 32'h00000000, 1'b1, 1'b1, 1'b0}, cins);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
